// File: rtl/dmem_resp.sv
// Word-organised data memory with byte/half/word writes and a fixed-latency read port.
// Reads go through a small IDLE/RBUSY FSM; faulty or rejected accesses pulse mem_err.
module dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE        = 32'h8000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_wbyte,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] Limit   = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  CntInit = 2'(LATENCY - 1);

  typedef enum logic {StIdle, StRbusy} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [1:0]      shift_q, shift_d;
  logic            inrange_q, inrange_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  // 33-bit offset so addresses below BASE go negative instead of wrapping.
  logic [32:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;

  assign offset   = {1'b0, mem_addr} - {1'b0, BASE};
  assign in_range = !offset[32] && (offset < Limit);
  assign idx      = offset[IdxW+1:2];

  logic        wr_ok;
  logic        wr_en;
  logic [3:0]  be;
  logic [31:0] wdata_rep;

  always_comb begin
    wr_ok     = in_range;
    be        = 4'b0000;
    wdata_rep = mem_wdata;
    case (mem_wbyte)
      2'b00: begin
        be        = 4'b0001 << mem_addr[1:0];
        wdata_rep = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be        = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{mem_wdata[15:0]}};
        if (mem_addr[0]) wr_ok = 1'b0;
      end
      2'b11: begin
        be = 4'b1111;
        if (mem_addr[1:0] != 2'b00) wr_ok = 1'b0;
      end
      default: wr_ok = 1'b0;
    endcase
  end

  assign wr_en = !rst && (state_q == StIdle) && mem_wen && wr_ok;

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  logic [31:0] rd_word;
  logic [31:0] rd_shifted;

  assign rd_word    = mem_q[idx_q];
  assign rd_shifted = rd_word >> {shift_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    inrange_d = inrange_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_wen) begin
          // A simultaneous read is dropped in favour of the write.
          err_d = !wr_ok || mem_ren;
        end else if (mem_ren) begin
          state_d   = StRbusy;
          cnt_d     = CntInit;
          idx_d     = idx;
          shift_d   = mem_addr[1:0];
          inrange_d = in_range;
        end
      end
      StRbusy: begin
        err_d = mem_ren || mem_wen;
        if (cnt_q == 2'd0) begin
          state_d  = StIdle;
          rvalid_d = 1'b1;
          rdata_d  = inrange_q ? rd_shifted : 32'h0;
          if (!inrange_q) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      idx_q     <= '0;
      shift_q   <= 2'd0;
      inrange_q <= 1'b0;
      rdata_q   <= 32'h0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      inrange_q <= inrange_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign mem_busy   = (state_q == StRbusy);
  assign mem_err    = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (LATENCY 1, 2, 3) share stimulus; a byte-level
// memory model feeds a queue of expected read results that is popped on each mem_rvalid.
module tb_dmem_resp;

  localparam logic [31:0] Base  = 32'h8000_0000;
  localparam int unsigned Depth = 1024;
  localparam logic [32:0] Lim   = 33'(4 * Depth);

  logic clk = 1'b0;
  logic rst, ren, wen;
  logic [31:0] addr, wdata;
  logic [1:0]  wbyte;
  logic [2:0][31:0] rdata;
  logic [2:0] rvalid, busy, err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [int unsigned];

  dmem_resp #(.DEPTH_WORDS(Depth), .BASE(Base), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wbyte(wbyte), .mem_rdata(rdata[0]), .mem_rvalid(rvalid[0]),
    .mem_busy(busy[0]), .mem_err(err[0])
  );
  dmem_resp #(.DEPTH_WORDS(Depth), .BASE(Base), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wbyte(wbyte), .mem_rdata(rdata[1]), .mem_rvalid(rvalid[1]),
    .mem_busy(busy[1]), .mem_err(err[1])
  );
  dmem_resp #(.DEPTH_WORDS(Depth), .BASE(Base), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wbyte(wbyte), .mem_rdata(rdata[2]), .mem_rvalid(rvalid[2]),
    .mem_busy(busy[2]), .mem_err(err[2])
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (5) cyc();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic rd_also, output logic legal);
    logic [32:0] off;
    logic [31:0] w;
    int unsigned wi;
    off   = {1'b0, a} - {1'b0, Base};
    legal = (off < Lim) && ((sz == 2'b00) || (sz == 2'b01 && !a[0]) ||
                            (sz == 2'b11 && a[1:0] == 2'b00));
    wi    = int'(off[31:2]);
    wen = 1'b1; ren = rd_also; addr = a; wdata = d; wbyte = sz;
    cyc();
    wen = 1'b0; ren = 1'b0;
    if (legal) begin
      w = model.exists(wi) ? model[wi] : 32'h0;
      case (sz)
        2'b00:   w[8*a[1:0] +: 8] = d[7:0];
        2'b01:   w[16*a[1] +: 16] = d[15:0];
        default: w = d;
      endcase
      model[wi] = w;
    end
  endtask

  function automatic exp_t exp_read(input logic [31:0] a);
    logic [32:0] off;
    exp_t x;
    int unsigned wi;
    off = {1'b0, a} - {1'b0, Base};
    wi  = int'(off[31:2]);
    if (off >= Lim) begin
      x.data = 32'h0;
      x.err  = 1'b1;
    end else begin
      x.data = (model.exists(wi) ? model[wi] : 32'h0) >> (8 * a[1:0]);
      x.err  = 1'b0;
    end
    return x;
  endfunction

  task automatic issue_read(input logic [31:0] a);
    sb_q.push_back(exp_read(a));
    ren = 1'b1; addr = a;
    cyc();
    ren = 1'b0;
  endtask

  // n = cycles from the request edge to mem_rvalid, or -1 on timeout.
  task automatic wait_resp(input int s, output logic [31:0] d, output logic e, output int n);
    d = 32'h0; e = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (rvalid[s]) begin
        d = rdata[s]; e = err[s]; n = c;
        return;
      end
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wbyte = 2'b11;
    cyc(); cyc();
    for (int s = 0; s < 3; s++) begin
      total++; if (rdata[s] !== 32'h0) begin bad++; $display("FAIL rst_rdata[%0d]: got %h want 0", s, rdata[s]); end
      total++; if (rvalid[s] !== 1'b0) begin bad++; $display("FAIL rst_rvalid[%0d]: got %b want 0", s, rvalid[s]); end
      total++; if (busy[s] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d]: got %b want 0", s, busy[s]); end
      total++; if (err[s] !== 1'b0) begin bad++; $display("FAIL rst_err[%0d]: got %b want 0", s, err[s]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_word_rw();
    logic legal, e; logic [31:0] d; int n; exp_t x;
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 2'b11, 1'b0, legal);
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL word_wr_err: got %b want 0", err[0]); end
    issue_read(32'h8000_0000);
    wait_resp(0, d, e, n);
    x = sb_q.pop_front();
    total++; if (n !== 1) begin bad++; $display("FAIL word_lat: got %0d want 1", n); end
    total++; if (d !== x.data) begin bad++; $display("FAIL word_data: got %h want %h", d, x.data); end
    total++; if (e !== x.err) begin bad++; $display("FAIL word_err: got %b want %b", e, x.err); end
    cyc();
    total++; if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL rvalid_pulse: got %b want 0", rvalid[0]); end
    total++; if (rdata[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rdata_hold: got %h want deadbeef", rdata[0]); end
    settle();
  endtask

  task automatic test_byte_half();
    logic [31:0] wa [4] = '{32'h8000_0004, 32'h8000_0006, 32'h8000_0008, 32'h8000_000A};
    logic [31:0] wd [4] = '{32'h0, 32'h0000_005A, 32'h1122_3344, 32'h0000_BEEF};
    logic [1:0]  ws [4] = '{2'b11, 2'b00, 2'b11, 2'b01};
    logic [31:0] ra [6] = '{32'h8000_0004, 32'h8000_0006, 32'h8000_0008, 32'h8000_0009,
                            32'h8000_000B, 32'h8000_0007};
    logic legal, e; logic [31:0] d; int n; exp_t x;
    for (int i = 0; i < 4; i++) begin
      do_write(wa[i], wd[i], ws[i], 1'b0, legal);
      total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL bh_wr_err[%0d]: got %b want 0", i, err[0]); end
    end
    for (int i = 0; i < 6; i++) begin
      issue_read(ra[i]);
      wait_resp(0, d, e, n);
      x = sb_q.pop_front();
      total++; if (n !== 1) begin bad++; $display("FAIL bh_lat[%0d]: got %0d want 1", i, n); end
      total++; if (d !== x.data) begin bad++; $display("FAIL bh_data[%0d]: got %h want %h", i, d, x.data); end
      total++; if (e !== x.err) begin bad++; $display("FAIL bh_err[%0d]: got %b want %b", i, e, x.err); end
    end
    settle();
  endtask

  task automatic test_bad_writes();
    logic [31:0] wa [5] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0000, 32'h8000_1000,
                            32'h7FFF_FFFC};
    logic [1:0]  ws [5] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b00};
    logic legal, e; logic [31:0] d; int n; exp_t x;
    for (int i = 0; i < 5; i++) begin
      do_write(wa[i], 32'hFFFF_FFFF, ws[i], 1'b0, legal);
      total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL bad_wr_err[%0d]: got %b want 1", i, err[0]); end
      cyc();
      total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL bad_wr_pulse[%0d]: got %b want 0", i, err[0]); end
    end
    for (int i = 0; i < 2; i++) begin
      issue_read(32'h8000_0000 + 32'(i * 4));
      wait_resp(0, d, e, n);
      x = sb_q.pop_front();
      total++; if (d !== x.data) begin bad++; $display("FAIL bad_wr_keep[%0d]: got %h want %h", i, d, x.data); end
      total++; if (e !== x.err) begin bad++; $display("FAIL bad_wr_rerr[%0d]: got %b want %b", i, e, x.err); end
    end
    settle();
  endtask

  task automatic test_out_of_range();
    logic [31:0] ra [5] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'h0000_0000, 32'hFFFF_FFFC,
                            32'h8000_0FFC};
    logic legal, e; logic [31:0] d; int n; exp_t x;
    do_write(32'h8000_0FFC, 32'h0BAD_F00D, 2'b11, 1'b0, legal);
    for (int i = 0; i < 5; i++) begin
      issue_read(ra[i]);
      wait_resp(0, d, e, n);
      x = sb_q.pop_front();
      total++; if (n !== 1) begin bad++; $display("FAIL oor_lat[%0d]: got %0d want 1", i, n); end
      total++; if (d !== x.data) begin bad++; $display("FAIL oor_data[%0d]: got %h want %h", i, d, x.data); end
      total++; if (e !== x.err) begin bad++; $display("FAIL oor_err[%0d]: got %b want %b", i, e, x.err); end
    end
    settle();
  endtask

  task automatic test_collide();
    logic legal, e; logic [31:0] d; int n; exp_t x;
    do_write(32'h8000_0014, 32'h1234_5678, 2'b11, 1'b1, legal);
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL coll_err: got %b want 1", err[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL coll_busy: got %b want 0", busy[0]); end
    issue_read(32'h8000_0014);
    wait_resp(0, d, e, n);
    x = sb_q.pop_front();
    total++; if (d !== x.data) begin bad++; $display("FAIL coll_data: got %h want %h", d, x.data); end
    total++; if (e !== x.err) begin bad++; $display("FAIL coll_rerr: got %b want %b", e, x.err); end
    settle();
  endtask

  task automatic test_busy_lat3();
    logic legal; exp_t x;
    pulse_rst();
    do_write(32'h8000_0010, 32'hCAFE_F00D, 2'b11, 1'b0, legal);
    sb_q.push_back(exp_read(32'h8000_0010));
    ren = 1'b1; addr = 32'h8000_0010;
    cyc();
    total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL l3_busy0: got %b want 1", busy[2]); end
    total++; if (err[2] !== 1'b0) begin bad++; $display("FAIL l3_err0: got %b want 0", err[2]); end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      total++; if (busy[2] !== (k < 3)) begin bad++; $display("FAIL l3_busy[%0d]: got %b want %b", k, busy[2], k < 3); end
      total++; if (rvalid[2] !== (k == 3)) begin bad++; $display("FAIL l3_rvalid[%0d]: got %b want %b", k, rvalid[2], k == 3); end
      total++; if (err[2] !== 1'b1) begin bad++; $display("FAIL l3_err[%0d]: got %b want 1", k, err[2]); end
    end
    x = sb_q.pop_front();
    total++; if (rdata[2] !== x.data) begin bad++; $display("FAIL l3_data: got %h want %h", rdata[2], x.data); end
    ren = 1'b0;
    cyc();
    total++; if (err[2] !== 1'b0) begin bad++; $display("FAIL l3_err_end: got %b want 0", err[2]); end
    total++; if (rvalid[2] !== 1'b0) begin bad++; $display("FAIL l3_rvalid_end: got %b want 0", rvalid[2]); end
    settle();
  endtask

  task automatic test_reset_abort();
    logic legal, e, seen; logic [31:0] d; int n; exp_t x;
    logic [31:0] ra [2] = '{32'h8000_0020, 32'h8000_0000};
    pulse_rst();
    do_write(32'h8000_0020, 32'hA5A5_0F0F, 2'b11, 1'b0, legal);
    ren = 1'b1; addr = 32'h8000_0020;
    cyc();
    ren = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy[1]); end
    seen = rvalid[1];
    repeat (4) begin cyc(); seen |= rvalid[1]; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_rvalid: got %b want 0", seen); end
    for (int i = 0; i < 2; i++) begin
      issue_read(ra[i]);
      wait_resp(1, d, e, n);
      x = sb_q.pop_front();
      total++; if (n !== 2) begin bad++; $display("FAIL abort_lat[%0d]: got %0d want 2", i, n); end
      total++; if (d !== x.data) begin bad++; $display("FAIL abort_data[%0d]: got %h want %h", i, d, x.data); end
      total++; if (e !== x.err) begin bad++; $display("FAIL abort_err[%0d]: got %b want %b", i, e, x.err); end
    end
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_bad_writes();
    test_out_of_range();
    test_collide();
    test_busy_lat3();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored.
REQ-002 Parameter BASE, default 32'h8000_0000: byte address of word 0.
REQ-003 Parameter LATENCY, default 1, legal range 1..4: cycles from request sample to read data valid.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port mem_ren, input, 1 bit: read request, sampled each cycle.
REQ-007 Port mem_wen, input, 1 bit: write request, sampled each cycle.
REQ-008 Port mem_addr, input, 32 bits: byte address.
REQ-009 Port mem_wdata, input, 32 bits: write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 Port mem_wbyte, input, 2 bits: write size; 2'b00 byte, 2'b01 half, 2'b11 word, 2'b10 reserved.
REQ-011 Port mem_rdata, output, 32 bits: registered read data.
REQ-012 Port mem_rvalid, output, 1 bit: one-cycle pulse marking new mem_rdata.
REQ-013 Port mem_busy, output, 1 bit: read in progress; new requests not accepted.
REQ-014 Port mem_err, output, 1 bit: one-cycle pulse flagging a rejected or faulty access.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and RBUSY, plus a 2-bit latency counter.
REQ-016 In IDLE with mem_wen=1, the block SHALL commit the write at that clock edge and remain in IDLE (write latency 0, no busy).
REQ-017 In IDLE with mem_ren=1 and mem_wen=0, the block SHALL capture the address, load the counter with LATENCY-1 and enter RBUSY.
REQ-018 In RBUSY, the counter SHALL decrement each cycle; at zero the block SHALL drive mem_rdata, pulse mem_rvalid for one cycle and return to IDLE, giving mem_rvalid exactly LATENCY cycles after the request edge.
REQ-019 mem_busy SHALL equal (state==RBUSY); requests arriving while busy SHALL be ignored and SHALL pulse mem_err.
REQ-020 mem_wen and mem_ren both high in IDLE: the write SHALL execute, the read SHALL be dropped, and mem_err SHALL pulse.
REQ-021 Word index SHALL be (mem_addr-BASE)>>2; the address is in range iff BASE <= mem_addr < BASE+4*DEPTH_WORDS, computed without 32-bit wrap (the 33-bit difference must be non-negative).
REQ-022 Read data SHALL be the aligned word shifted right by 8*mem_addr[1:0], zero-filled, so byte/half data lands in the low bits.
REQ-023 Out-of-range read: mem_rdata SHALL be 32'h0 with the normal mem_rvalid timing, and mem_err SHALL pulse with mem_rvalid.
REQ-024 Write lanes: word writes all 4 bytes; half writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0]; byte writes lane addr[1:0] from wdata[7:0].
REQ-025 Misaligned write (word with addr[1:0]!=0, half with addr[0]=1), reserved mem_wbyte=2'b10, or out-of-range write: no storage change, mem_err pulses next cycle.
REQ-026 A write to the word being read while in RBUSY is impossible by REQ-019; read data SHALL reflect storage as of the request edge.
REQ-027 mem_rdata SHALL hold its last value between reads.

Reset
REQ-028 While rst=1 at a clock edge: state IDLE, counter 0, mem_rdata 32'h0, mem_rvalid 0, mem_busy 0, mem_err 0.
REQ-029 Reset during RBUSY SHALL abort the read with no mem_rvalid pulse.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 rst has priority over any simultaneous request.

Verification
REQ-032 LATENCY=1: word write 32'hDEADBEEF @8000_0000, read @8000_0000 -> mem_rvalid 1 cycle after request, mem_rdata=DEADBEEF.
REQ-033 Byte write 8'h5A @8000_0006 onto word 0, then read @8000_0004 -> mem_rdata=0x005A0000; read @8000_0006 -> 0x0000005A.
REQ-034 Half write @8000_0001 and word write @8000_0002 -> mem_err pulse each, storage unchanged.
REQ-035 LATENCY=3: read, then ren held high during RBUSY -> busy 3 cycles, rvalid at cycle 3, mem_err each busy-cycle request.
REQ-036 Read @7FFF_FFFC and @BASE+4*DEPTH_WORDS -> rdata 0, rvalid and mem_err coincident.
REQ-037 rst asserted 1 cycle after read request (LATENCY=2) -> no rvalid, busy 0; prior stored data still readable after reset.
